// File: rtl/mobilenet_v1_param_pkg.sv
// Shared types and constants for the MobileNet v1 parameter loader: record types,
// payload lengths, header length, payload field offsets and the parser state encoding.
package mobilenet_v1_param_pkg;

    typedef enum logic [1:0] {
        PT_CONV1 = 2'd0,
        PT_DW    = 2'd1,
        PT_PW_RQ = 2'd2,
        PT_PW_W  = 2'd3
    } rec_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CKSUM,
        ST_WRITE,
        ST_DRAIN
    } loader_state_e;

    localparam int HDR_BYTES = 6;
    localparam int LEN_CONV1 = 21;
    localparam int LEN_DW    = 17;
    localparam int LEN_PW_RQ = 12;
    localparam int LEN_PW_W  = 1;

    // Byte offsets of each field inside wr_data, as seen by the RAM readers
    localparam int OFF_C1_W0       = 0;
    localparam int OFF_C1_BIAS_ACC = 9;
    localparam int OFF_C1_MUL      = 13;
    localparam int OFF_C1_BIAS_RQ  = 15;
    localparam int OFF_C1_SHIFT    = 19;
    localparam int OFF_C1_RELU6    = 20;
    localparam int OFF_DW_W0       = 0;
    localparam int OFF_DW_MUL      = 9;
    localparam int OFF_DW_BIAS     = 11;
    localparam int OFF_DW_SHIFT    = 15;
    localparam int OFF_DW_RELU6    = 16;
    localparam int OFF_PW_BIAS_ACC = 0;
    localparam int OFF_PW_MUL      = 4;
    localparam int OFF_PW_BIAS_RQ  = 6;
    localparam int OFF_PW_SHIFT    = 10;
    localparam int OFF_PW_RELU6    = 11;
    localparam int OFF_PWW_WEIGHT  = 0;

    function automatic int payload_len(input rec_type_e t);
        int len;
        len = LEN_PW_W;
        case (t)
            PT_CONV1: len = LEN_CONV1;
            PT_DW:    len = LEN_DW;
            PT_PW_RQ: len = LEN_PW_RQ;
            PT_PW_W:  len = LEN_PW_W;
            default:  len = LEN_PW_W;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mobilenet_v1_param_loader_if.sv
// Byte-stream input, RAM write port and status of the parameter loader.
// err_cksum exists only when PARAM_LOADER_CKSUM_EN is defined.
interface mobilenet_v1_param_loader_if #(
    parameter int DIM_W     = 16,
    parameter int REC_BYTES = 21,
    parameter int TYPE_W    = 2
);
    logic                   s_valid;
    logic                   s_ready;
    logic [7:0]             s_data;
    logic                   s_last;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [TYPE_W-1:0]      wr_type;
    logic [DIM_W-1:0]       wr_layer;
    logic [DIM_W-1:0]       wr_idx_a;
    logic [DIM_W-1:0]       wr_idx_b;
    logic [REC_BYTES*8-1:0] wr_data;
    logic [15:0]            rec_count;
    logic                   err_bad_type;
    logic                   err_trunc;
`ifdef PARAM_LOADER_CKSUM_EN
    logic                   err_cksum;
`endif

    // Host / RAM side
    modport master (
`ifdef PARAM_LOADER_CKSUM_EN
        input  err_cksum,
`endif
        output s_valid, s_data, s_last, wr_ready,
        input  s_ready, wr_valid, wr_type, wr_layer, wr_idx_a, wr_idx_b, wr_data,
               rec_count, err_bad_type, err_trunc
    );

    // Loader side
    modport slave (
`ifdef PARAM_LOADER_CKSUM_EN
        output err_cksum,
`endif
        input  s_valid, s_data, s_last, wr_ready,
        output s_ready, wr_valid, wr_type, wr_layer, wr_idx_a, wr_idx_b, wr_data,
               rec_count, err_bad_type, err_trunc
    );

endinterface

// File: rtl/mobilenet_v1_param_loader.sv
// Parses a little-endian byte stream into typed parameter records and issues each one on the
// parameter RAM write port. Define PARAM_LOADER_CKSUM_EN to require a trailing XOR checksum byte.
module mobilenet_v1_param_loader
    import mobilenet_v1_param_pkg::*;
#(
    parameter int DIM_W     = 16,
    parameter int REC_BYTES = 21,
    parameter int TYPE_W    = 2
) (
    input logic clk,
    input logic rst_n,
    mobilenet_v1_param_loader_if.slave bus
);

    localparam int CNT_W = $clog2(REC_BYTES + 1);

    loader_state_e          state;
    rec_type_e              rec_type;
    logic [CNT_W-1:0]       cnt;
    logic [47:0]            hdr;
    logic [REC_BYTES*8-1:0] data;
    logic                   s_ready;
    logic                   wr_valid;
    logic [15:0]            rec_count;
    logic                   err_bad_type;
    logic                   err_trunc;
    logic                   xfer;
    logic                   last_pay;

    assign xfer     = bus.s_valid && s_ready;
    assign last_pay = (int'(cnt) == payload_len(rec_type) - 1);

`ifdef PARAM_LOADER_CKSUM_EN
    logic [7:0] xsum;
    logic       err_cksum;

    // Running XOR of every record byte; the type byte restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xsum <= '0;
        end else if (xfer) begin
            xsum <= (state == ST_IDLE) ? bus.s_data : (xsum ^ bus.s_data);
        end
    end

    assign bus.err_cksum = err_cksum;
`endif

    // Header and payload are assembled in place, so the write fields hold still during WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rec_type     <= PT_CONV1;
            cnt          <= '0;
            hdr          <= '0;
            data         <= '0;
            s_ready      <= 1'b0;
            wr_valid     <= 1'b0;
            rec_count    <= '0;
            err_bad_type <= 1'b0;
            err_trunc    <= 1'b0;
`ifdef PARAM_LOADER_CKSUM_EN
            err_cksum    <= 1'b0;
`endif
        end else begin
            err_bad_type <= 1'b0;
            err_trunc    <= 1'b0;
`ifdef PARAM_LOADER_CKSUM_EN
            err_cksum    <= 1'b0;
`endif
            s_ready      <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        if (bus.s_data[7:2] != 6'd0) begin
                            err_bad_type <= 1'b1;
                            state        <= bus.s_last ? ST_IDLE : ST_DRAIN;
                        end else if (bus.s_last) begin
                            err_trunc <= 1'b1;
                        end else begin
                            rec_type <= rec_type_e'(bus.s_data[1:0]);
                            cnt      <= '0;
                            hdr      <= '0;
                            data     <= '0;
                            state    <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        hdr[cnt*8 +: 8] <= bus.s_data;
                        if (bus.s_last) begin
                            err_trunc <= 1'b1;
                            state     <= ST_IDLE;
                        end else if (int'(cnt) == HDR_BYTES - 1) begin
                            cnt   <= '0;
                            state <= ST_PAYLOAD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        data[cnt*8 +: 8] <= bus.s_data;
                        if (last_pay) begin
`ifdef PARAM_LOADER_CKSUM_EN
                            if (bus.s_last) begin
                                err_trunc <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                state <= ST_CKSUM;
                            end
`else
                            wr_valid <= 1'b1;
                            s_ready  <= 1'b0;
                            state    <= ST_WRITE;
`endif
                        end else if (bus.s_last) begin
                            err_trunc <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_CKSUM: begin
`ifdef PARAM_LOADER_CKSUM_EN
                    if (xfer) begin
                        if (bus.s_data == xsum) begin
                            wr_valid <= 1'b1;
                            s_ready  <= 1'b0;
                            state    <= ST_WRITE;
                        end else begin
                            err_cksum <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_WRITE: begin
                    if (bus.wr_ready) begin
                        wr_valid  <= 1'b0;
                        rec_count <= rec_count + 16'd1;
                        state     <= ST_IDLE;
                    end else begin
                        s_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (xfer && bus.s_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Header fields are always two bytes on the wire and are resized to DIM_W here
    assign bus.s_ready      = s_ready;
    assign bus.wr_valid     = wr_valid;
    assign bus.wr_type      = TYPE_W'(rec_type);
    assign bus.wr_layer     = DIM_W'(hdr[15:0]);
    assign bus.wr_idx_a     = DIM_W'(hdr[31:16]);
    assign bus.wr_idx_b     = (rec_type == PT_PW_W) ? DIM_W'(hdr[47:32]) : '0;
    assign bus.wr_data      = data;
    assign bus.rec_count    = rec_count;
    assign bus.err_bad_type = err_bad_type;
    assign bus.err_trunc    = err_trunc;

endmodule
